// File: rtl/conv2_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : conv2_pkg
//  Purpose  : Shared constants and types for the conv2 layer (window generator
//             and filter array). Image geometry, word width, and the 3x3
//             window bundle type.
//  Revision : 1.0  initial release
// ============================================================================
package conv2_pkg;

    localparam int DATA_W   = 32;          // pixel word width
    localparam int IMG_W    = 17;          // input columns per row
    localparam int IMG_H    = 21;          // input rows per channel
    localparam int CH_NUM   = 32;          // channels per frame
    localparam int OUT_W    = IMG_W - 2;   // output columns (valid padding)
    localparam int OUT_H    = IMG_H - 2;   // output rows (valid padding)

    localparam int COL_W    = $clog2(IMG_W);
    localparam int ROW_W    = $clog2(IMG_H);
    localparam int CH_W     = $clog2(CH_NUM);
    localparam int CH_IDX_W = 8;

    // 3x3 window, [0] = top-left ... [8] = bottom-right, row-major
    typedef logic [DATA_W-1:0] win_t [0:8];

endpackage
`default_nettype wire

// File: rtl/conv2_line_buf.sv
`default_nettype none
// ============================================================================
//  Module   : conv2_line_buf
//  Purpose  : One-row delay line. Every write returns the word written DEPTH
//             writes earlier. Circular pointer over an uncleared RAM.
//  Ports    : clk       - clock
//             rst_n     - asynchronous active-low reset (pointer only)
//             i_wr_en   - push i_din, advance pointer
//             i_din     - word to push
//             o_dout    - word written DEPTH pushes ago (valid with i_wr_en)
//  Revision : 1.0  initial release
// ============================================================================
module conv2_line_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [PTR_W-1:0] r_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_wr_en) begin
            r_ptr <= (r_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
        end
    end

    // RAM is deliberately not reset; the caller's row gating masks stale data.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[r_ptr] <= i_din;
        end
    end

    // Read-before-write: the slot about to be overwritten holds the oldest word.
    assign o_dout = r_mem[r_ptr];

endmodule
`default_nettype wire

// File: rtl/conv2_window_gen.sv
`default_nettype none
// ============================================================================
//  Module   : conv2_window_gen
//  Purpose  : 3x3 valid-padding, stride-1 sliding-window generator over a
//             raster-order, channel-major pixel stream. Emits one registered
//             window per completing pixel with channel/frame boundary flags.
//  Ports    : clk           - clock
//             rst_n         - asynchronous active-low reset
//             i_pix_in      - input pixel (DATA_W)
//             i_pix_valid   - pixel accepted this edge, no backpressure
//             o_window      - 9 words packed, word k at [k*DATA_W +: DATA_W],
//                             word 0 = top-left, word 8 = bottom-right
//             o_win_valid   - one-cycle pulse per new window
//             o_ch_idx      - channel of the current / most recent window
//             o_ch_done     - pulses with the last window of a channel
//             o_frame_done  - pulses with the last window of channel CH_NUM-1
//  Revision : 1.0  initial release
// ============================================================================
module conv2_window_gen
    import conv2_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     i_pix_in,
    input  logic                  i_pix_valid,
    output logic [9*DATA_W-1:0]   o_window,
    output logic                  o_win_valid,
    output logic [CH_IDX_W-1:0]   o_ch_idx,
    output logic                  o_ch_done,
    output logic                  o_frame_done
);

    // ---------------------------------------------------------------- counters
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [CH_W-1:0]  r_ch;

    logic w_col_last;
    logic w_row_last;
    logic w_ch_last;
    logic w_emit;

    assign w_col_last = (r_col == COL_W'(IMG_W - 1));
    assign w_row_last = (r_row == ROW_W'(IMG_H - 1));
    assign w_ch_last  = (r_ch  == CH_W'(CH_NUM - 1));

    // Rows 0/1 of a channel and columns 0/1 of a row only prime the buffers.
    assign w_emit = i_pix_valid && (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
            r_ch  <= '0;
        end else if (i_pix_valid) begin
            if (w_col_last) begin
                r_col <= '0;
                if (w_row_last) begin
                    r_row <= '0;
                    r_ch  <= w_ch_last ? '0 : r_ch + 1'b1;
                end else begin
                    r_row <= r_row + 1'b1;
                end
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------ line buffers
    logic [DATA_W-1:0] w_lb0_dout;   // row r-1, same column
    logic [DATA_W-1:0] w_lb1_dout;   // row r-2, same column

    conv2_line_buf #(
        .WIDTH (DATA_W),
        .DEPTH (IMG_W)
    ) u_lb0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_wr_en (i_pix_valid),
        .i_din   (i_pix_in),
        .o_dout  (w_lb0_dout)
    );

    conv2_line_buf #(
        .WIDTH (DATA_W),
        .DEPTH (IMG_W)
    ) u_lb1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_wr_en (i_pix_valid),
        .i_din   (w_lb0_dout),
        .o_dout  (w_lb1_dout)
    );

    // ------------------------------------------------------- 3x3 shift array
    // Only the two older columns are stored; the newest column comes straight
    // from {lb1, lb0, pix} so a window can be registered on the same edge.
    // r_sa[row*2 + 0] = column c-2, r_sa[row*2 + 1] = column c-1.
    logic [DATA_W-1:0] r_sa [0:5];
    win_t              w_win_next;
    logic [9*DATA_W-1:0] w_win_packed;

    always_comb begin
        w_win_next[2] = w_lb1_dout;
        w_win_next[5] = w_lb0_dout;
        w_win_next[8] = i_pix_in;
        for (int r = 0; r < 3; r++) begin
            w_win_next[r*3 + 0] = r_sa[r*2 + 0];
            w_win_next[r*3 + 1] = r_sa[r*2 + 1];
        end
        w_win_packed = '0;
        for (int k = 0; k < 9; k++) begin
            w_win_packed[k*DATA_W +: DATA_W] = w_win_next[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sa <= '{default: '0};
        end else if (i_pix_valid) begin
            for (int r = 0; r < 3; r++) begin
                r_sa[r*2 + 0] <= w_win_next[r*3 + 1];
                r_sa[r*2 + 1] <= w_win_next[r*3 + 2];
            end
        end
    end

    // -------------------------------------------------------- output register
    logic [9*DATA_W-1:0] r_window;
    logic                r_win_valid;
    logic [CH_IDX_W-1:0] r_ch_idx;
    logic                r_ch_done;
    logic                r_frame_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_window     <= '0;
            r_win_valid  <= 1'b0;
            r_ch_idx     <= '0;
            r_ch_done    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_win_valid  <= w_emit;
            r_ch_done    <= w_emit && w_col_last && w_row_last;
            r_frame_done <= w_emit && w_col_last && w_row_last && w_ch_last;
            if (w_emit) begin
                r_window <= w_win_packed;
                r_ch_idx <= CH_IDX_W'(r_ch);
            end
        end
    end

    assign o_window     = r_window;
    assign o_win_valid  = r_win_valid;
    assign o_ch_idx     = r_ch_idx;
    assign o_ch_done    = r_ch_done;
    assign o_frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_conv2_window_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv2_window_gen
//  Purpose  : Directed self-checking bench for conv2_window_gen. Pixels carry
//             (ch<<16)|(row<<8)|col so every expected window word is known.
//  Revision : 1.0  initial release
// ============================================================================
module tb_conv2_window_gen;
    import conv2_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [DATA_W-1:0]     i_pix_in = '0;
    logic                  i_pix_valid = 1'b0;
    logic [9*DATA_W-1:0]   o_window;
    logic                  o_win_valid;
    logic [CH_IDX_W-1:0]   o_ch_idx;
    logic                  o_ch_done;
    logic                  o_frame_done;

    always #5 clk = ~clk;

    conv2_window_gen dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_pix_in     (i_pix_in),
        .i_pix_valid  (i_pix_valid),
        .o_window     (o_window),
        .o_win_valid  (o_win_valid),
        .o_ch_idx     (o_ch_idx),
        .o_ch_done    (o_ch_done),
        .o_frame_done (o_frame_done)
    );

    localparam int LAST_PIX = IMG_W * IMG_H - 1;
    localparam int FIRST_WIN_PIX = 2 * IMG_W + 2;

    int n_vec = 0;
    int n_bad = 0;

    logic [9*DATA_W-1:0] exp_win;
    logic [7:0]          exp_ch;
    int                  win_cnt;
    int                  cd_cnt;
    int                  fd_cnt;
    logic [31:0]         cd_word8;
    logic [7:0]          fd_ch;

    task automatic chk(input string tag, input logic [9*DATA_W-1:0] obs,
                       input logic [9*DATA_W-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc(input int ch, input int row, input int col);
        return 32'((ch << 16) | (row << 8) | col);
    endfunction

    function automatic logic [31:0] word(input int k);
        return o_window[k*DATA_W +: DATA_W];
    endfunction

    // Apply one cycle (valid pixel or bubble) and check every output against
    // the window expected from the pixel coordinates.
    task automatic drive(input bit v, input int ch, input int row, input int col);
        bit ev;
        bit ecd;
        @(negedge clk);
        i_pix_valid = v;
        i_pix_in    = v ? enc(ch, row, col) : 32'($urandom);
        @(posedge clk);
        #1;
        ev  = v && (row >= 2) && (col >= 2);
        ecd = ev && (row == IMG_H - 1) && (col == IMG_W - 1);
        if (ev) begin
            for (int k = 0; k < 9; k++)
                exp_win[k*DATA_W +: DATA_W] = enc(ch, row - 2 + k / 3, col - 2 + k % 3);
            exp_ch = 8'(ch);
        end
        chk("win_valid",  o_win_valid, ev);
        chk("window",     o_window, exp_win);
        chk("ch_idx",     o_ch_idx, exp_ch);
        chk("ch_done",    o_ch_done, ecd);
        chk("frame_done", o_frame_done, ecd && (ch == CH_NUM - 1));
        if (o_win_valid) win_cnt++;
        if (o_ch_done) begin
            cd_cnt++;
            cd_word8 = word(8);
        end
        if (o_frame_done) begin
            fd_cnt++;
            fd_ch = o_ch_idx;
        end
    endtask

    // Stream pixels first..last (raster index) of one channel, with optional
    // random bubbles before each pixel.
    task automatic stream(input int ch, input int first, input int last, input int gap_pct);
        for (int i = first; i <= last; i++) begin
            for (int g = 0; g < 4 && $urandom_range(99) < gap_pct; g++)
                drive(1'b0, 0, 0, 0);
            drive(1'b1, ch, i / IMG_W, i % IMG_W);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_window"},     o_window, '0);
        chk({tag, "_win_valid"},  o_win_valid, '0);
        chk({tag, "_ch_idx"},     o_ch_idx, '0);
        chk({tag, "_ch_done"},    o_ch_done, '0);
        chk({tag, "_frame_done"}, o_frame_done, '0);
    endtask

    initial begin
        exp_win  = '0;
        exp_ch   = '0;
        win_cnt  = 0;
        cd_cnt   = 0;
        fd_cnt   = 0;
        cd_word8 = '0;
        fd_ch    = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // First window of channel 0
        stream(0, 0, FIRST_WIN_PIX, 0);
        chk("first_cnt",   win_cnt, 1);
        chk("first_w0",    word(0), 32'h000000);
        chk("first_w4",    word(4), 32'h000101);
        chk("first_w8",    word(8), 32'h000202);

        // Row wrap: rest of row 2, then row 3 cols 0..2 (two idle cycles)
        stream(0, FIRST_WIN_PIX + 1, 2 * IMG_W + IMG_W - 1, 0);
        chk("row2_cnt",    win_cnt, OUT_W);
        stream(0, 3 * IMG_W, 3 * IMG_W + 1, 0);
        chk("rowwrap_idle", win_cnt, OUT_W);
        stream(0, 3 * IMG_W + 2, 3 * IMG_W + 2, 0);
        chk("rowwrap_w0",  word(0), 32'h000100);
        chk("rowwrap_w8",  word(8), 32'h000302);

        // Remainder of channel 0
        stream(0, 3 * IMG_W + 3, LAST_PIX, 0);
        chk("ch0_windows", win_cnt, OUT_W * OUT_H);
        chk("ch0_chdone",  cd_cnt, 1);
        chk("ch0_last_w8", cd_word8, 32'h001410);

        // Channel 1 with 30% bubbles, back-to-back after channel 0
        win_cnt = 0;
        stream(1, 0, FIRST_WIN_PIX, 30);
        chk("ch1_w0",      word(0), 32'h010000);
        chk("ch1_idx",     o_ch_idx, 8'd1);
        stream(1, FIRST_WIN_PIX + 1, LAST_PIX, 30);
        chk("ch1_windows", win_cnt, OUT_W * OUT_H);
        chk("ch1_chdone",  cd_cnt, 2);

        // Rest of the frame
        for (int ch = 2; ch < CH_NUM; ch++)
            stream(ch, 0, LAST_PIX, (ch % 4 == 0) ? 10 : 0);
        chk("frame_done_cnt", fd_cnt, 1);
        chk("frame_done_ch",  fd_ch, 8'd31);
        chk("frame_chdone",   cd_cnt, CH_NUM);

        // Frame wrap back to channel 0
        win_cnt = 0;
        stream(0, 0, FIRST_WIN_PIX, 0);
        chk("wrap_idx",    o_ch_idx, 8'd0);
        chk("wrap_w0",     word(0), 32'h000000);
        chk("wrap_cnt",    win_cnt, 1);

        // Advance to channel 3 row 10, then reset asynchronously mid-cycle
        stream(0, FIRST_WIN_PIX + 1, LAST_PIX, 0);
        stream(1, 0, LAST_PIX, 0);
        stream(2, 0, LAST_PIX, 0);
        stream(3, 0, 10 * IMG_W + 5, 0);
        chk("pre_rst_idx", o_ch_idx, 8'd3);
        @(negedge clk);
        i_pix_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(posedge clk);
        #1;
        chk_all_zero("midrst_hold");
        @(negedge clk);
        rst_n   = 1'b1;
        exp_win = '0;
        exp_ch  = '0;

        // After reset the stream restarts at (ch 0, row 0, col 0)
        win_cnt = 0;
        stream(0, 0, FIRST_WIN_PIX - 1, 0);
        chk("post_rst_early", win_cnt, 0);
        stream(0, FIRST_WIN_PIX, FIRST_WIN_PIX, 0);
        chk("post_rst_cnt", win_cnt, 1);
        chk("post_rst_w0",  word(0), 32'h000000);
        chk("post_rst_w4",  word(4), 32'h000101);
        chk("post_rst_w8",  word(8), 32'h000202);
        chk("post_rst_idx", o_ch_idx, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
